microwave_timer_ctrl: RTL and testbench
=======================================

// Module: microwave_timer_ctrl
// PURPOSE
//  Sequencer for the 4-digit BCD down-counter chain (timer_ten x4, digits D3..D0).
//  Collects keypad digits, loads the chain, generates the 1-tick count enable,
//  handles start/stop/clear/door events and stops the magnetron when the chain reaches zero.
//  Sits between keypad/buttons and the counter chain; the chain's own tc cascade is external.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per count tick (bench uses 4); must be >= 2
// PORTS
//  clk         in   1   system clock, rising edge
//  clrn        in   1   asynchronous active-low reset
//  key_valid   in   1   one-cycle strobe: key holds a new keypad code
//  key         in   4   keypad code; 0-9 accepted, 10-15 ignored
//  start       in   1   one-cycle start strobe
//  stop        in   1   one-cycle stop/pause strobe
//  clear       in   1   one-cycle cancel strobe
//  door_closed in   1   level, 1 = door closed
//  timer_zero  in   1   AND of the four digit zero flags (registered in chain)
//  loadn       out  1   active-low parallel load to all digits
//  data        out  16  load value {D3,D2,D1,D0}, BCD
//  en          out  1   count enable to D0, one-cycle pulse per tick
//  mag_on      out  1   magnetron enable
//  done        out  1   cook-complete flag
//  state_o     out  3   current state code (debug)
// BEHAVIOUR
//  Reset (clrn=0, async): state IDLE, entry=0, presc=0, loadn=1, en=0, data=0, mag_on=0, done=0.
//  All outputs registered. States (code): IDLE 0, SET 1, LOAD 2, RUN 3, PAUSE 4, CLR 5, DONE 6.
//  Event priority per cycle: clear > stop > door open > start > key. At most one acts per cycle.
//  Keys: valid digit k in IDLE/SET -> entry <= {entry[11:0],k}, go SET (D3 shifted out, lost).
//    In DONE: entry <= {12'h000,k}, done<=0, go SET. Keys ignored in LOAD/RUN/PAUSE/CLR.
//  IDLE/SET + start: if door_closed & entry!=0 -> LOAD; else ignored (no state change).
//  LOAD (1 cycle): loadn=0, data=entry; presc<=0; next RUN.
//  RUN: mag_on=1. presc counts 0..TICK_DIV-1; at TICK_DIV-1, en=1 for one cycle, presc<=0.
//    timer_zero sampled each RUN cycle, ignored in the cycle right after an en pulse
//    (chain flag not yet updated). Otherwise timer_zero=1 -> DONE; en suppressed in that cycle.
//    stop or door_closed=0 -> PAUSE: mag_on<=0, presc held (phase kept).
//  PAUSE: start & door_closed -> RUN, no reload, presc resumes. stop -> CLR.
//  CLR (1 cycle): loadn=0, data=0, entry<=0, done<=0; next IDLE. clear in any state except
//    CLR -> CLR. Reset during any state (including LOAD/RUN) returns to IDLE immediately.
//  DONE: done=1, mag_on=0, en=0. start ignored. clear -> CLR. key -> SET (above).
//  Outside LOAD/CLR: loadn=1, data=entry. Outside RUN: en=0, mag_on=0.
//  Final tick: en pulse takes chain 0001->0000; timer_zero rises next cycle; DONE follows.
// TESTING (TICK_DIV=4, chain of 4 timer_ten models attached)
//  keys 1,2,3 then start, door closed -> one LOAD cycle loadn=0 data=16'h0123, then RUN,
//    mag_on=1, en every 4th cycle.
//  entry 0002, start -> after 2 en pulses chain=0000, DONE next cycle: done=1, mag_on=0, en=0.
//  RUN then stop -> PAUSE, mag_on=0, chain value held; start -> RUN, tick phase continues, no load.
//  RUN, door_closed=0 -> PAUSE; start with door open ignored; close door + start -> RUN.
//  PAUSE + stop, or clear in RUN -> CLR: loadn=0, data=0 one cycle, then IDLE, entry=0.
//  start with entry=0 or door open -> stays IDLE/SET, loadn stays 1; key 12 -> entry unchanged;
//    clear and start same cycle -> CLR wins; clrn low mid-RUN -> all outputs at reset values.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer sequencer: collects keypad digits, loads the external BCD
// down-counter chain, paces its count enable and runs the magnetron until zero.
module microwave_timer_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        key_valid,
    input  logic [3:0]  key,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        door_closed,
    input  logic        timer_zero,
    output logic        loadn,
    output logic [15:0] data,
    output logic        en,
    output logic        mag_on,
    output logic        done,
    output logic [2:0]  state_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_CLR   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     entry_q, entry_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            loadn_q, loadn_d;
    logic [15:0]     data_q, data_d;
    logic            en_q, en_d;
    logic            mag_q, mag_d;
    logic            done_q, done_d;
    logic            ign_q;

    logic            key_ok;
    logic [PW-1:0]   presc_nxt;

    assign key_ok    = key_valid && (key <= 4'd9);
    assign presc_nxt = (presc_q == PMAX) ? '0 : presc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        presc_d = presc_q;
        case (state_q)
            S_IDLE, S_SET: begin
                if (clear) begin
                    state_d = S_CLR;
                end else if (start && door_closed && (entry_q != 16'h0000)) begin
                    state_d = S_LOAD;
                end else if (key_ok) begin
                    entry_d = {entry_q[11:0], key};
                    state_d = S_SET;
                end
            end
            S_LOAD: begin
                presc_d = '0;
                state_d = clear ? S_CLR : S_RUN;
            end
            S_RUN: begin
                // Prescaler advances on every RUN cycle, including the one that
                // pauses, so an already-issued tick is never repeated on resume.
                presc_d = presc_nxt;
                if (clear) begin
                    state_d = S_CLR;
                end else if (stop || !door_closed) begin
                    state_d = S_PAUSE;
                end else if (timer_zero && !ign_q) begin
                    state_d = S_DONE;
                end
            end
            S_PAUSE: begin
                if (clear || stop) begin
                    state_d = S_CLR;
                end else if (start && door_closed) begin
                    state_d = S_RUN;
                end
            end
            S_CLR: begin
                state_d = S_IDLE;
            end
            S_DONE: begin
                if (clear) begin
                    state_d = S_CLR;
                end else if (key_ok) begin
                    entry_d = {12'h000, key};
                    state_d = S_SET;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_CLR) begin
            entry_d = 16'h0000;
        end
    end

    // Outputs are registered from the next state so they line up with state_o.
    always_comb begin
        loadn_d = !((state_d == S_LOAD) || (state_d == S_CLR));
        data_d  = entry_d;
        mag_d   = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
        en_d    = (state_d == S_RUN) && (presc_d == PMAX) && !timer_zero;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            entry_q <= 16'h0000;
            presc_q <= '0;
            loadn_q <= 1'b1;
            data_q  <= 16'h0000;
            en_q    <= 1'b0;
            mag_q   <= 1'b0;
            done_q  <= 1'b0;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            presc_q <= presc_d;
            loadn_q <= loadn_d;
            data_q  <= data_d;
            en_q    <= en_d;
            mag_q   <= mag_d;
            done_q  <= done_d;
            // The chain's zero flag lags the count by a cycle after each tick.
            ign_q   <= en_q;
        end
    end

    assign loadn   = loadn_q;
    assign data    = data_q;
    assign en      = en_q;
    assign mag_on  = mag_q;
    assign done    = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl with a behavioural 4-digit BCD down-counter chain.
module tb_microwave_timer_ctrl;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key = 4'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        door_closed = 1'b1;
    logic        timer_zero;
    logic        loadn;
    logic [15:0] data;
    logic        en;
    logic        mag_on;
    logic        done;
    logic [2:0]  state_o;

    logic [15:0] chain_q;
    int checks = 0;
    int errors = 0;

    microwave_timer_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key(key),
        .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
        .timer_zero(timer_zero), .loadn(loadn), .data(data), .en(en),
        .mag_on(mag_on), .done(done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r = v;
        borrow = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (borrow) begin
                if (r[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)       chain_q <= 16'h0000;
        else if (!loadn) chain_q <= data;
        else if (en)     chain_q <= bcd_dec(chain_q);
    end
    assign timer_zero = (chain_q == 16'h0000);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] k);
        key_valid = 1'b1;
        key = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        tick();
        checks++;
        if ({state_o, loadn, data, en, mag_on, done} !== {3'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got st=%0d ld=%b d=%h en=%b mag=%b done=%b want st=0 ld=1 d=0000 en=0 mag=0 done=0",
                     state_o, loadn, data, en, mag_on, done);
        end
        clrn = 1'b1;
        tick();
    endtask

    task automatic test_load_run();
        press_key(4'd1);
        checks++;
        if ({state_o, data} !== {3'd1, 16'h0001}) begin
            errors++;
            $display("FAIL first_key got st=%0d d=%h want st=1 d=0001", state_o, data);
        end
        press_key(4'd2);
        press_key(4'd3);
        checks++;
        if ({state_o, data} !== {3'd1, 16'h0123}) begin
            errors++;
            $display("FAIL entry_123 got st=%0d d=%h want st=1 d=0123", state_o, data);
        end
        door_closed = 1'b1;
        pulse_start();
        checks++;
        if ({state_o, loadn, data, mag_on, en} !== {3'd2, 1'b0, 16'h0123, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_cycle got st=%0d ld=%b d=%h mag=%b en=%b want st=2 ld=0 d=0123 mag=0 en=0",
                     state_o, loadn, data, mag_on, en);
        end
        tick();
        checks++;
        if ({state_o, loadn, mag_on, en} !== {3'd3, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL run_entry got st=%0d ld=%b mag=%b en=%b want st=3 ld=1 mag=1 en=0",
                     state_o, loadn, mag_on, en);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (en !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL en_cadence cycle %0d got %b want %b", i, en, ((i % 4) == 3));
            end
        end
        checks++;
        if ({chain_q, mag_on, loadn} !== {16'h0121, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL chain_after_2_ticks got chain=%h mag=%b ld=%b want 0121 1 1", chain_q, mag_on, loadn);
        end
        pulse_clear();
        checks++;
        if ({state_o, loadn, data, mag_on, en} !== {3'd5, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear_in_run got st=%0d ld=%b d=%h mag=%b en=%b want st=5 ld=0 d=0000 mag=0 en=0",
                     state_o, loadn, data, mag_on, en);
        end
        tick();
        checks++;
        if ({state_o, loadn, data} !== {3'd0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL clr_to_idle got st=%0d ld=%b d=%h want st=0 ld=1 d=0000", state_o, loadn, data);
        end
    endtask

    task automatic test_done();
        int done_at;
        int pulses;
        done_at = -1;
        pulses = 0;
        press_key(4'd2);
        pulse_start();
        tick();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (en === 1'b1) pulses++;
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
        end
        checks++;
        if (done_at != 10) begin
            errors++;
            $display("FAIL done_latency got %0d want 10 (-1 = timeout)", done_at);
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL done_en_pulses got %0d want 2", pulses);
        end
        checks++;
        if ({state_o, done, mag_on, en, chain_q} !== {3'd6, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL done_outputs got st=%0d done=%b mag=%b en=%b chain=%h want 6 1 0 0 0000",
                     state_o, done, mag_on, en, chain_q);
        end
        pulse_start();
        checks++;
        if ({state_o, done, loadn} !== {3'd6, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL start_in_done got st=%0d done=%b ld=%b want 6 1 1", state_o, done, loadn);
        end
        press_key(4'd5);
        checks++;
        if ({state_o, done, data} !== {3'd1, 1'b0, 16'h0005}) begin
            errors++;
            $display("FAIL key_in_done got st=%0d done=%b d=%h want 1 0 0005", state_o, done, data);
        end
        pulse_clear();
        tick();
    endtask

    task automatic test_pause_resume();
        press_key(4'd4);
        press_key(4'd5);
        pulse_start();
        tick();
        tick();
        tick();
        pulse_stop();
        checks++;
        if ({state_o, mag_on, en} !== {3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_to_pause got st=%0d mag=%b en=%b want 4 0 0", state_o, mag_on, en);
        end
        repeat (3) tick();
        checks++;
        if ({state_o, chain_q} !== {3'd4, 16'h0045}) begin
            errors++;
            $display("FAIL pause_hold got st=%0d chain=%h want 4 0045", state_o, chain_q);
        end
        pulse_start();
        checks++;
        if ({state_o, loadn, mag_on, en} !== {3'd3, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL resume_phase got st=%0d ld=%b mag=%b en=%b want 3 1 1 1", state_o, loadn, mag_on, en);
        end
        tick();
        checks++;
        if ({state_o, en, chain_q} !== {3'd3, 1'b0, 16'h0044}) begin
            errors++;
            $display("FAIL resume_count got st=%0d en=%b chain=%h want 3 0 0044", state_o, en, chain_q);
        end
        pulse_stop();
        pulse_stop();
        checks++;
        if ({state_o, loadn, data} !== {3'd5, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL pause_stop_clr got st=%0d ld=%b d=%h want 5 0 0000", state_o, loadn, data);
        end
        tick();
        checks++;
        if ({state_o, data} !== {3'd0, 16'h0000}) begin
            errors++;
            $display("FAIL pause_clr_idle got st=%0d d=%h want 0 0000", state_o, data);
        end
    endtask

    task automatic test_door();
        press_key(4'd7);
        door_closed = 1'b0;
        pulse_start();
        checks++;
        if ({state_o, loadn} !== {3'd1, 1'b1}) begin
            errors++;
            $display("FAIL start_door_open got st=%0d ld=%b want 1 1", state_o, loadn);
        end
        door_closed = 1'b1;
        pulse_start();
        tick();
        checks++;
        if ({state_o, mag_on} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL door_run got st=%0d mag=%b want 3 1", state_o, mag_on);
        end
        door_closed = 1'b0;
        tick();
        checks++;
        if ({state_o, mag_on} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL door_open_pause got st=%0d mag=%b want 4 0", state_o, mag_on);
        end
        pulse_start();
        checks++;
        if ({state_o, mag_on} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL start_while_open got st=%0d mag=%b want 4 0", state_o, mag_on);
        end
        door_closed = 1'b1;
        pulse_start();
        checks++;
        if ({state_o, mag_on, loadn} !== {3'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL door_resume got st=%0d mag=%b ld=%b want 3 1 1", state_o, mag_on, loadn);
        end
        pulse_clear();
        tick();
    endtask

    task automatic test_misc();
        pulse_start();
        checks++;
        if ({state_o, loadn} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL start_entry_zero got st=%0d ld=%b want 0 1", state_o, loadn);
        end
        press_key(4'd12);
        checks++;
        if ({state_o, data} !== {3'd0, 16'h0000}) begin
            errors++;
            $display("FAIL bad_key_idle got st=%0d d=%h want 0 0000", state_o, data);
        end
        press_key(4'd9);
        press_key(4'd12);
        checks++;
        if ({state_o, data} !== {3'd1, 16'h0009}) begin
            errors++;
            $display("FAIL bad_key_set got st=%0d d=%h want 1 0009", state_o, data);
        end
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        press_key(4'd4);
        checks++;
        if (data !== 16'h1234) begin
            errors++;
            $display("FAIL shift_out got d=%h want 1234", data);
        end
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        checks++;
        if ({state_o, loadn, data} !== {3'd5, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL clear_beats_start got st=%0d ld=%b d=%h want 5 0 0000", state_o, loadn, data);
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        press_key(4'd3);
        pulse_start();
        tick();
        tick();
        checks++;
        if ({state_o, mag_on} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL midrun_setup got st=%0d mag=%b want 3 1", state_o, mag_on);
        end
        #1;
        clrn = 1'b0;
        #1;
        checks++;
        if ({state_o, loadn, data, en, mag_on, done} !== {3'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_run got st=%0d ld=%b d=%h en=%b mag=%b done=%b want 0 1 0000 0 0 0",
                     state_o, loadn, data, en, mag_on, done);
        end
        tick();
        clrn = 1'b1;
        tick();
        checks++;
        if ({state_o, mag_on, data} !== {3'd0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL post_reset_idle got st=%0d mag=%b d=%h want 0 0 0000", state_o, mag_on, data);
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_done();
        test_pause_resume();
        test_door();
        test_misc();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
